// File: rtl/mygo_chan_pkg.sv
// mygo_chan_pkg: shared types and constants for the mygo channel runtime blocks
package mygo_chan_pkg;
  localparam int MYGO_CHAN_WIDTH = 32;
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    CHECK = 3'd1,
    RECV  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } cons_state_t;
endpackage

// File: rtl/mygo_chan_sum_consumer.sv
// mygo_chan_sum_consumer: reads COUNT words from a valid/ready channel and sends their wrapping sum once
module mygo_chan_sum_consumer
  import mygo_chan_pkg::*;
#(
  parameter int          WIDTH  = MYGO_CHAN_WIDTH,
  parameter int unsigned COUNT  = 4,
  parameter bit          REPEAT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);
  cons_state_t      state, state_nx;
  logic [WIDTH-1:0] sum;
  logic [31:0]      idx;
  logic             take;
  assign take = (state == RECV) && in_valid;
  // next-state decode; unrecognised encodings fall back to INIT
  always_comb begin
    state_nx = INIT;
    case (state)
      INIT:    state_nx = CHECK;
      CHECK:   state_nx = (idx < COUNT) ? RECV : SEND;
      RECV:    state_nx = in_valid ? CHECK : RECV;
      SEND:    state_nx = out_ready ? (REPEAT ? INIT : DONE) : SEND;
      DONE:    state_nx = DONE;
      default: state_nx = INIT;
    endcase
  end
  // state register, wrapping accumulator and accepted-word index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      sum   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      sum   <= (state == INIT) ? '0 : take ? sum + in_data : sum;
      idx   <= (state == INIT) ? '0 : take ? idx + 32'd1 : idx;
    end
  end
  assign in_ready  = state == RECV;
  assign out_valid = state == SEND;
  assign done      = state == DONE;
  assign out_data  = sum;
endmodule
